// File: rtl/video_timing_pkg.sv
// Shared 720p60 video timing defaults and total-size helpers for the
// signal generator, encoder top and pattern generators.
package video_timing_pkg;

    localparam int DEF_ACTIVE_H_PIXELS = 1280;
    localparam int DEF_H_FRONT_PORCH   = 110;
    localparam int DEF_H_SYNC_WIDTH    = 40;
    localparam int DEF_H_BACK_PORCH    = 220;
    localparam int DEF_ACTIVE_LINES    = 720;
    localparam int DEF_V_FRONT_PORCH   = 5;
    localparam int DEF_V_SYNC_WIDTH    = 5;
    localparam int DEF_V_BACK_PORCH    = 20;
    localparam int DEF_FPS             = 60;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FC_W     = 6;

    function automatic int line_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_ACTIVE_H_PIXELS, DEF_H_FRONT_PORCH,
                                            DEF_H_SYNC_WIDTH, DEF_H_BACK_PORCH);
    localparam int DEF_V_TOTAL = line_total(DEF_ACTIVE_LINES, DEF_V_FRONT_PORCH,
                                            DEF_V_SYNC_WIDTH, DEF_V_BACK_PORCH);

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with increment enable; o_wrap flags the increment
// that takes the count from MODULUS-1 back to 0.
module mod_counter #(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 1650
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_inc && (r_count == LAST);
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line counters, sync, active-draw,
// new-frame pulse and frame counter, all registered and mutually aligned.
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
    parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
    parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int FPS             = DEF_FPS
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out
);

    localparam int H_TOTAL = line_total(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
    localparam int V_TOTAL = line_total(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);

    localparam logic [HCOUNT_W-1:0] H_ACT      = HCOUNT_W'(ACTIVE_H_PIXELS);
    localparam logic [HCOUNT_W-1:0] H_SYNC_BEG = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [HCOUNT_W-1:0] H_SYNC_END = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [VCOUNT_W-1:0] V_ACT      = VCOUNT_W'(ACTIVE_LINES);
    localparam logic [VCOUNT_W-1:0] V_SYNC_BEG = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [VCOUNT_W-1:0] V_SYNC_END = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [FC_W-1:0]     FC_LAST    = FC_W'(FPS - 1);

    if (H_TOTAL - 1 >= (1 << HCOUNT_W)) begin : g_h_range_check
        $error("video_sig_gen: H_TOTAL-1 does not fit in hcount_out");
    end
    if (V_TOTAL - 1 >= (1 << VCOUNT_W)) begin : g_v_range_check
        $error("video_sig_gen: V_TOTAL-1 does not fit in vcount_out");
    end
    if (FPS > (1 << FC_W) || FPS < 1) begin : g_fps_range_check
        $error("video_sig_gen: FPS must be within 1..64");
    end

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [HCOUNT_W-1:0] w_h;
    logic [VCOUNT_W-1:0] w_v;
    logic                w_h_wrap;
    logic                w_unused_v_wrap;
    logic                w_ad;
    logic                w_hs;
    logic                w_vs;
    logic                w_nf;
    logic                r_started;

    // Assert immediately, release two clocks after rst_n_in rises.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Counters run one pixel ahead; the output stage registers their decode,
    // so the first edge after release presents (0,0) while they move to (1,0).
    mod_counter #(
        .WIDTH   (HCOUNT_W),
        .MODULUS (H_TOTAL)
    ) u_hcnt (
        .i_clk   (clk_in),
        .i_rst_n (w_rst_n),
        .i_inc   (1'b1),
        .o_count (w_h),
        .o_wrap  (w_h_wrap)
    );

    mod_counter #(
        .WIDTH   (VCOUNT_W),
        .MODULUS (V_TOTAL)
    ) u_vcnt (
        .i_clk   (clk_in),
        .i_rst_n (w_rst_n),
        .i_inc   (w_h_wrap),
        .o_count (w_v),
        .o_wrap  (w_unused_v_wrap)
    );

    always_comb begin
        w_ad = (w_h < H_ACT) && (w_v < V_ACT);
        w_hs = (w_h >= H_SYNC_BEG) && (w_h < H_SYNC_END);
        w_vs = (w_v >= V_SYNC_BEG) && (w_v < V_SYNC_END);
        w_nf = (w_h == H_ACT) && (w_v == V_ACT);
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_started  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else begin
            r_started  <= 1'b1;
            hcount_out <= w_h;
            vcount_out <= w_v;
            hs_out     <= w_hs;
            vs_out     <= w_vs;
            ad_out     <= w_ad;
            nf_out     <= w_nf;
            if (r_started && nf_out) begin
                fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + 1'b1;
            end
        end
    end

endmodule

// File: doc/video_sig_gen.md
VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- ACTIVE_H_PIXELS, 1280, active pixels per line.
- H_FRONT_PORCH, 110, pixels between end of active and start of hsync.
- H_SYNC_WIDTH, 40, hsync width in pixels.
- H_BACK_PORCH, 220, pixels between end of hsync and the next line.
- ACTIVE_LINES, 720, active lines per frame.
- V_FRONT_PORCH, 5, lines between end of active and start of vsync.
- V_SYNC_WIDTH, 5, vsync width in lines.
- V_BACK_PORCH, 20, lines between end of vsync and the next frame.
- FPS, 60, frame-counter modulus.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk_in, in, 1, pixel clock; single clock domain.
- rst_n_in, in, 1, asynchronous active-low reset.
- hcount_out, out, 11, horizontal pixel index.
- vcount_out, out, 10, vertical line index.
- hs_out, out, 1, hsync, active high.
- vs_out, out, 1, vsync, active high.
- ad_out, out, 1, active draw; feeds the encoder's ve_in.
- nf_out, out, 1, new-frame pulse.
- fc_out, out, 6, frame count.

Function
REQ-003 H_TOTAL SHALL be the sum of ACTIVE_H_PIXELS and the three H parameters (default 1650); V_TOTAL SHALL be the sum of ACTIVE_LINES and the three V parameters (default 750).
REQ-004 hcount_out SHALL increment by 1 per clock and wrap from H_TOTAL-1 to 0.
REQ-005 vcount_out SHALL increment by 1 only on the hcount wrap cycle, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-006 All outputs SHALL be registered and mutually aligned: hs_out, vs_out, ad_out and nf_out describe the pixel shown on hcount_out/vcount_out in the same cycle.
REQ-007 ad_out SHALL be 1 iff hcount < ACTIVE_H_PIXELS and vcount < ACTIVE_LINES.
REQ-008 hs_out SHALL be 1 iff ACTIVE_H_PIXELS+H_FRONT_PORCH <= hcount < ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH (default 1390..1429), on every line including blanking lines.
REQ-009 vs_out SHALL be 1 iff ACTIVE_LINES+V_FRONT_PORCH <= vcount < ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH (default 725..729), for entire lines.
REQ-010 nf_out SHALL pulse for exactly one cycle when hcount==ACTIVE_H_PIXELS and vcount==ACTIVE_LINES, i.e. the first blanking pixel after the last active pixel.
REQ-011 fc_out SHALL increment on the cycle nf_out is 1 and wrap from FPS-1 to 0; its new value SHALL be visible the cycle after the nf_out pulse.
REQ-012 Simultaneous hcount and vcount wrap at (H_TOTAL-1, V_TOTAL-1) SHALL produce (0,0) with ad_out=1 on the next cycle, with no skipped or repeated pixel.
REQ-013 Counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1; an elaboration-time check SHALL fail if they do not fit, or if FPS > 64.

Reset
REQ-014 While rst_n_in=0, all outputs SHALL be 0; assertion SHALL take effect asynchronously, including mid-frame.
REQ-015 An internal started flag SHALL be cleared by reset; the first rising edge after deassertion SHALL set it and present pixel (0,0) with ad_out=1, then advance normally.
REQ-016 Reset deassertion SHALL be synchronized internally with a 2-flop release synchronizer, so the first active edge occurs 2 clocks after rst_n_in rises.

Structure
REQ-017 Default 720p60 timing constants and the H_TOTAL/V_TOTAL derivations SHALL live in shared package video_timing_pkg, for reuse by the encoder top and the pattern generators.
REQ-018 One sub-module, mod_counter (parameterized width and modulus, inc enable, wrap flag output), SHALL be instantiated twice: horizontal counter with inc tied to 1, vertical counter with inc tied to the horizontal wrap.

Verification
REQ-019 Reset is released, then 1650 clocks are run -> first active cycle shows (0,0) ad=1; (1279,0) ad=1; (1280,0) ad=0; hs=1 exactly at hcount 1390..1429; hcount returns to 0 with vcount=1.
REQ-020 One full frame (1,237,500 clocks) is run -> exactly 720*1280=921,600 ad=1 cycles, exactly 750 hs pulses, and vs=1 for exactly 5 lines (vcount 725..729).
REQ-021 The frame-boundary pixel is checked -> (1649,749) is followed by (0,0) with ad=1; nf=1 only at (1280,720).
REQ-022 61 frames are run -> fc counts 0..59, then wraps to 0 on the 60th nf pulse, then reaches 1 on the 61st.
REQ-023 rst_n_in is asserted at (700,400) -> all outputs are 0 immediately, without waiting for a clock edge; after release the sequence restarts at (0,0).
REQ-024 The block is run with small parameters (4,1,1,1 / 3,1,1,1, FPS=3) -> H_TOTAL=7, V_TOTAL=6; the bench checks every cycle against a reference model over 3 frames.
